// File: rtl/hermes_output_arbiter.sv
// Packet-level round-robin arbiter for one Hermes router output link with credit flow control.
// Optional stall watchdog is enabled by defining ARB_WATCHDOG_EN.
module hermes_output_arbiter #(
    parameter int FLIT_WIDTH     = 32,
    parameter int NPORTS         = 5,
    parameter int SIZE_WIDTH     = 16,
    parameter int WATCHDOG_LIMIT = 1024
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic [NPORTS-1:0]            req_i,
    input  logic [NPORTS*FLIT_WIDTH-1:0] flit_i,
    output logic [NPORTS-1:0]            pop_o,
    input  logic                         credit_i,
    output logic                         tx_o,
    output logic [FLIT_WIDTH-1:0]        data_o,
    output logic [NPORTS-1:0]            grant_o,
    output logic                         busy_o,
    output logic                         timeout_o
);

    localparam int IDX_W = (NPORTS > 1) ? $clog2(NPORTS) : 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        HEADER  = 2'd1,
        SIZE    = 2'd2,
        PAYLOAD = 2'd3
    } state_t;

    state_t                 state_reg, state_next;
    logic [NPORTS-1:0]      grant_reg, grant_next;
    logic [IDX_W-1:0]       last_reg, last_next;
    logic [SIZE_WIDTH-1:0]  remaining_reg, remaining_next;

    logic [FLIT_WIDTH-1:0]  flit_arr [NPORTS];
    logic [FLIT_WIDTH-1:0]  owner_flit;
    logic                   owner_req;
    logic                   xfer;
    logic                   pick_valid;
    logic [IDX_W-1:0]       pick_idx;

    generate
        for (genvar gi = 0; gi < NPORTS; gi++) begin : g_unpack
            assign flit_arr[gi] = flit_i[gi*FLIT_WIDTH +: FLIT_WIDTH];
        end
    endgenerate

    // Grant is one-hot, so an AND-OR mux selects the owner's flit and request.
    always_comb begin
        owner_flit = '0;
        owner_req  = 1'b0;
        for (int k = 0; k < NPORTS; k++) begin
            if (grant_reg[k]) begin
                owner_flit = owner_flit | flit_arr[k];
                owner_req  = owner_req | req_i[k];
            end
        end
    end

    // Scan last+NPORTS down to last+1 so the closest requester after last wins.
    always_comb begin
        int cand;
        pick_valid = 1'b0;
        pick_idx   = last_reg;
        cand       = 0;
        for (int off = NPORTS; off >= 1; off--) begin
            cand = int'(last_reg) + off;
            if (cand >= NPORTS) begin
                cand = cand - NPORTS;
            end
            if (req_i[cand[IDX_W-1:0]]) begin
                pick_valid = 1'b1;
                pick_idx   = cand[IDX_W-1:0];
            end
        end
    end

    assign xfer = (state_reg != IDLE) && owner_req && credit_i;

    always_comb begin
        state_next     = state_reg;
        grant_next     = grant_reg;
        last_next      = last_reg;
        remaining_next = remaining_reg;
        case (state_reg)
            IDLE: begin
                if (pick_valid) begin
                    grant_next           = '0;
                    grant_next[pick_idx] = 1'b1;
                    last_next            = pick_idx;
                    state_next           = HEADER;
                end
            end
            HEADER: begin
                if (xfer) begin
                    state_next = SIZE;
                end
            end
            SIZE: begin
                if (xfer) begin
                    remaining_next = owner_flit[SIZE_WIDTH-1:0];
                    if (owner_flit[SIZE_WIDTH-1:0] == '0) begin
                        state_next = IDLE;
                        grant_next = '0;
                    end else begin
                        state_next = PAYLOAD;
                    end
                end
            end
            PAYLOAD: begin
                if (xfer) begin
                    // Guarded decrement: the counter can never wrap below zero.
                    if (remaining_reg != '0) begin
                        remaining_next = remaining_reg - 1'b1;
                    end
                    if (remaining_reg <= SIZE_WIDTH'(1)) begin
                        state_next = IDLE;
                        grant_next = '0;
                    end
                end
            end
            default: begin
                state_next = IDLE;
                grant_next = '0;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg     <= IDLE;
            grant_reg     <= '0;
            last_reg      <= IDX_W'(NPORTS - 1);
            remaining_reg <= '0;
        end else begin
            state_reg     <= state_next;
            grant_reg     <= grant_next;
            last_reg      <= last_next;
            remaining_reg <= remaining_next;
        end
    end

    assign tx_o    = xfer;
    assign pop_o   = xfer ? grant_reg : '0;
    assign data_o  = xfer ? owner_flit : '0;
    assign grant_o = grant_reg;
    assign busy_o  = (state_reg != IDLE);

`ifdef ARB_WATCHDOG_EN
    localparam int WD_W = $clog2(WATCHDOG_LIMIT + 1);

    logic [WD_W-1:0] stall_cnt_reg, stall_cnt_next;
    logic            timeout_reg, timeout_next;

    // Counts consecutive owned cycles with no transfer; saturates at the limit.
    always_comb begin
        stall_cnt_next = '0;
        timeout_next   = timeout_reg;
        if ((state_reg != IDLE) && !xfer) begin
            if (stall_cnt_reg == WD_W'(WATCHDOG_LIMIT)) begin
                stall_cnt_next = stall_cnt_reg;
            end else begin
                stall_cnt_next = stall_cnt_reg + 1'b1;
            end
        end
        if (stall_cnt_next == WD_W'(WATCHDOG_LIMIT)) begin
            timeout_next = 1'b1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            stall_cnt_reg <= '0;
            timeout_reg   <= 1'b0;
        end else begin
            stall_cnt_reg <= stall_cnt_next;
            timeout_reg   <= timeout_next;
        end
    end

    assign timeout_o = timeout_reg;
`else
    assign timeout_o = 1'b0;
`endif

endmodule

// File: tb/tb_hermes_output_arbiter.sv
// Randomized self-checking bench for hermes_output_arbiter against a packet-queue reference model.
module tb_hermes_output_arbiter;
    localparam int FW       = 32;
    localparam int NP       = 5;
    localparam int SW       = 16;
    localparam int WD_LIMIT = 8;

    typedef logic [FW-1:0] flit_t;

    logic              clock = 1'b0;
    logic              reset;
    logic [NP-1:0]     req_i;
    logic [NP*FW-1:0]  flit_i;
    logic [NP-1:0]     pop_o;
    logic              credit_i;
    logic              tx_o;
    logic [FW-1:0]     data_o;
    logic [NP-1:0]     grant_o;
    logic              busy_o;
    logic              timeout_o;

    always #5 clock = ~clock;

    hermes_output_arbiter #(
        .FLIT_WIDTH(FW), .NPORTS(NP), .SIZE_WIDTH(SW), .WATCHDOG_LIMIT(WD_LIMIT)
    ) dut (
        .clock(clock), .reset(reset), .req_i(req_i), .flit_i(flit_i), .pop_o(pop_o),
        .credit_i(credit_i), .tx_o(tx_o), .data_o(data_o), .grant_o(grant_o),
        .busy_o(busy_o), .timeout_o(timeout_o)
    );

    int checks = 0;
    int errors = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: whole packets queued per input, owner plus flits left in its packet.
    flit_t   q [NP][$];
    int      m_owner, m_left, m_last, m_stall;
    bit      m_timeout;
    int      bubble_pct, credit_pct;
    logic [NP-1:0] req_mask;
    bit      prev_busy;
    logic [NP-1:0] grant_log[$];
    flit_t   data_log[$];

    task automatic model_reset();
        m_owner = -1; m_left = 0; m_last = NP - 1; m_stall = 0; m_timeout = 1'b0;
        prev_busy = 1'b0;
    endtask

    task automatic push_packet(input int p, input int size);
        flit_t sz;
        sz = {16'($urandom), 16'(size)};
        q[p].push_back(flit_t'({8'hC0 + 8'(p), 24'($urandom)}));
        q[p].push_back(sz);
        for (int i = 0; i < size; i++) q[p].push_back(flit_t'($urandom));
    endtask

    task automatic drive_inputs();
        for (int k = 0; k < NP; k++) begin
            if (q[k].size() > 0) begin
                req_i[k] = !req_mask[k] && ($urandom_range(0, 99) >= bubble_pct);
                flit_i[k*FW +: FW] = q[k][0];
            end else begin
                req_i[k] = 1'b0;
                flit_i[k*FW +: FW] = flit_t'($urandom);
            end
        end
        credit_i = ($urandom_range(0, 99) < credit_pct);
    endtask

    // Called at posedge+1; checks at negedge, advances the model, returns at next posedge+1.
    task automatic run_cycle();
        bit xf;
        flit_t sz;
        logic [NP-1:0] exp_grant;
        drive_inputs();
        @(negedge clock);
        xf = (m_owner >= 0) && req_i[m_owner] && credit_i;
        exp_grant = (m_owner >= 0) ? NP'(1 << m_owner) : '0;
        check_eq("grant", grant_o, exp_grant);
        check_eq("busy", busy_o, m_owner >= 0);
        check_eq("tx", tx_o, xf);
        check_eq("pop", pop_o, xf ? exp_grant : '0);
        check_eq("data", data_o, xf ? q[m_owner][0] : '0);
        check_eq("timeout", timeout_o, m_timeout);
        if (tx_o) data_log.push_back(data_o);
        if (busy_o && !prev_busy) grant_log.push_back(grant_o);
        prev_busy = busy_o;
`ifdef ARB_WATCHDOG_EN
        if (m_owner >= 0 && !xf) begin
            if (m_stall < WD_LIMIT) m_stall++;
            if (m_stall == WD_LIMIT) m_timeout = 1'b1;
        end else begin
            m_stall = 0;
        end
`endif
        if (m_owner >= 0) begin
            if (xf) begin
                void'(q[m_owner].pop_front());
                m_left--;
                if (m_left == 0) begin
                    $display("packet done: port=%0d at %0t", m_owner, $time);
                    m_owner = -1;
                end
            end
        end else if (req_i != '0) begin
            for (int off = 1; off <= NP; off++) begin
                int c;
                c = (m_last + off) % NP;
                if (m_owner < 0 && req_i[c]) begin
                    m_owner = c;
                    m_last  = c;
                    sz      = q[c][1];
                    m_left  = 2 + int'(sz[SW-1:0]);
                end
            end
        end
        @(posedge clock);
        #1;
    endtask

    task automatic run_cycles(input int n);
        for (int i = 0; i < n; i++) run_cycle();
    endtask

    task automatic do_reset();
        req_i = '0; credit_i = 1'b0; req_mask = '0;
        for (int k = 0; k < NP; k++) q[k].delete();
        reset = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        check_eq("rst_grant", grant_o, '0);
        check_eq("rst_busy", busy_o, 1'b0);
        check_eq("rst_tx", tx_o, 1'b0);
        check_eq("rst_pop", pop_o, '0);
        check_eq("rst_data", data_o, '0);
        check_eq("rst_timeout", timeout_o, 1'b0);
        reset = 1'b0;
        model_reset();
    endtask

    initial begin
        reset = 1'b1; req_i = '0; flit_i = '0; credit_i = 1'b0; req_mask = '0;
        bubble_pct = 0; credit_pct = 100;
        model_reset();
        @(posedge clock);
        #1;
        do_reset();

        // 1: single WEST packet, header/size/payload with free credit
        q[1].push_back(32'h0101); q[1].push_back(32'd2);
        q[1].push_back(32'hA);    q[1].push_back(32'hB);
        data_log.delete(); grant_log.delete();
        run_cycles(7);
        check_eq("t1_ngrants", grant_log.size(), 1);
        check_eq("t1_grant", grant_log[0], 5'b00010);
        check_eq("t1_nflits", data_log.size(), 4);
        check_eq("t1_d0", data_log[0], 32'h0101);
        check_eq("t1_d1", data_log[1], 32'd2);
        check_eq("t1_d2", data_log[2], 32'hA);
        check_eq("t1_d3", data_log[3], 32'hB);

        // 2: all inputs requesting size-0 packets; round-robin order from EAST
        do_reset();
        for (int k = 0; k < NP; k++) begin push_packet(k, 0); push_packet(k, 0); end
        grant_log.delete();
        run_cycles(18);
        check_eq("t2_ngrants", grant_log.size(), 6);
        check_eq("t2_g0", grant_log[0], 5'b00001);
        check_eq("t2_g1", grant_log[1], 5'b00010);
        check_eq("t2_g2", grant_log[2], 5'b00100);
        check_eq("t2_g3", grant_log[3], 5'b01000);
        check_eq("t2_g4", grant_log[4], 5'b10000);
        check_eq("t2_g5", grant_log[5], 5'b00001);
        run_cycles(15);

        // 3: size-3 packet, credit withheld 3 cycles after first payload flit
        do_reset();
        push_packet(3, 3);
        data_log.delete();
        run_cycles(4);
        credit_pct = 0;
        run_cycles(3);
        credit_pct = 100;
        run_cycles(4);
        check_eq("t3_nflits", data_log.size(), 5);

        // 4: owner WEST drops its request mid-payload while NORTH waits
        do_reset();
        push_packet(1, 4);
        push_packet(2, 1);
        grant_log.delete();
        run_cycles(4);
        req_mask = 5'b00010;
        run_cycles(2);
        req_mask = '0;
        run_cycles(10);
        check_eq("t4_ngrants", grant_log.size(), 2);
        check_eq("t4_first", grant_log[0], 5'b00010);
        check_eq("t4_second", grant_log[1], 5'b00100);

        // 6: long stall in HEADER exercises the watchdog
        do_reset();
        push_packet(0, 1);
        run_cycles(1);
        credit_pct = 0;
        run_cycles(WD_LIMIT);
`ifdef ARB_WATCHDOG_EN
        check_eq("t6_timeout_set", timeout_o, 1'b1);
`else
        check_eq("t6_timeout_tied", timeout_o, 1'b0);
`endif
        credit_pct = 100;
        run_cycles(6);
`ifdef ARB_WATCHDOG_EN
        check_eq("t6_timeout_sticky", timeout_o, 1'b1);
`else
        check_eq("t6_timeout_idle", timeout_o, 1'b0);
`endif

        // Random traffic with bubbles and credit gaps
        do_reset();
        bubble_pct = 15; credit_pct = 70;
        for (int cyc = 0; cyc < 1500; cyc++) begin
            for (int k = 0; k < NP; k++) begin
                if (q[k].size() < 8 && $urandom_range(0, 99) < 10)
                    push_packet(k, ($urandom_range(0, 9) == 0) ? int'($urandom_range(6, 20))
                                                               : int'($urandom_range(0, 5)));
            end
            run_cycle();
        end

        // 5: asynchronous reset while SOUTH owns the link mid-payload
        do_reset();
        bubble_pct = 0; credit_pct = 100;
        push_packet(3, 10);
        run_cycles(5);
        drive_inputs();
        #1;
        check_eq("t5_pre_tx", tx_o, 1'b1);
        reset = 1'b1;
        #1;
        check_eq("t5_grant", grant_o, '0);
        check_eq("t5_tx", tx_o, 1'b0);
        check_eq("t5_pop", pop_o, '0);
        check_eq("t5_busy", busy_o, 1'b0);
        #1;
        reset = 1'b0;
        req_i = '0;
        for (int k = 0; k < NP; k++) q[k].delete();
        model_reset();
        @(posedge clock);
        #1;
        push_packet(0, 1);
        push_packet(3, 1);
        grant_log.delete();
        run_cycles(12);
        check_eq("t5_ngrants", grant_log.size(), 2);
        check_eq("t5_first", grant_log[0], 5'b00001);
        check_eq("t5_second", grant_log[1], 5'b01000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/hermes_output_arbiter.md
Name: hermes_output_arbiter

Overview:
Packet-level output-port arbiter for one Hermes router output (EAST/WEST/NORTH/SOUTH/LOCAL). It shares one output link among the 5 router input buffers using round-robin. A grant is held for the whole wormhole packet: header flit, size flit, then the payload flits. Traffic is gated by credit-based flow control from the downstream router or PE.

Parameters:
FLIT_WIDTH, 32, flit width in bits
NPORTS, 5, number of requesting input ports (index order EAST=0, WEST=1, NORTH=2, SOUTH=3, LOCAL=4)
SIZE_WIDTH, 16, low bits of the size flit holding the payload flit count; must be <= FLIT_WIDTH
WATCHDOG_LIMIT, 1024, stall-cycle threshold, used only with ARB_WATCHDOG_EN

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
req_i  in  NPORTS  input k has a valid head-of-buffer flit routed to this output
flit_i  in  NPORTS*FLIT_WIDTH  head flits; port k occupies bits [k*FLIT_WIDTH +: FLIT_WIDTH]
pop_o  out  NPORTS  one-hot; input k's head flit is consumed this cycle
credit_i  in  1  downstream can accept a flit this cycle
tx_o  out  1  data_o valid this cycle
data_o  out  FLIT_WIDTH  outgoing flit
grant_o  out  NPORTS  one-hot current owner; 0 when idle
busy_o  out  1  a packet is in progress
timeout_o  out  1  sticky watchdog flag

Behaviour:
- Clock and reset: single clock domain; reset is asynchronous and active-high.
- Reset values (applied immediately on reset assertion):
  - state=IDLE, grant_o=0, busy_o=0, tx_o=0, pop_o=0, data_o=0, timeout_o=0
  - remaining counter=0
  - priority pointer last=LOCAL, so EAST has first priority after reset.
- Transfer condition: xfer = (state!=IDLE) & req_i[owner] & credit_i.
  - tx_o=xfer and pop_o=grant_o when xfer, else 0. Both are combinational.
  - data_o = flit_i[owner] when xfer, else 0.
- FSM states: IDLE, HEADER, SIZE, PAYLOAD.
- IDLE:
  - If any req_i bit is set, pick the first requester scanning last+1, last+2, ... modulo NPORTS.
  - Register the one-hot grant, set last to the winner, go to HEADER.
  - No transfer occurs in IDLE, so there is 1 cycle of latency from a request to the earliest header transfer.
- HEADER: on xfer, go to SIZE.
- SIZE:
  - On xfer, load remaining = flit_i[owner][SIZE_WIDTH-1:0].
  - If the loaded value is 0, go to IDLE; otherwise go to PAYLOAD.
- PAYLOAD:
  - On xfer, decrement remaining.
  - If remaining==1 at the xfer, go to IDLE.
- Leaving to IDLE clears grant_o and busy_o on the same edge. One idle bubble cycle always separates consecutive packets on this output.
- busy_o = (state!=IDLE).
- Stalls:
  - credit_i=0 or req_i[owner]=0 in a non-IDLE state: no transfer; state, grant and remaining are held.
  - Requests from non-owners are ignored until the packet ends.
- Owner req drop mid-packet: treated as an upstream bubble, not a release. The grant is held.
- Maximum packet length is 2 + (2^SIZE_WIDTH - 1) flits. The remaining counter never wraps, because decrement happens only when remaining>=1 in PAYLOAD.
- Reset mid-packet: the packet is abandoned. Upstream and downstream recovery belongs to the router, not this block.

Optional Feature:
ARB_WATCHDOG_EN
- With the macro defined:
  - A stall counter counts consecutive non-IDLE cycles without xfer.
  - The counter clears on any xfer or on return to IDLE.
  - When the counter reaches WATCHDOG_LIMIT, timeout_o is set and stays 1 until reset.
  - Arbitration is unaffected; there is no forced release.
- Without the macro: no counter logic, and timeout_o is tied to 0.

Test Plan:
1. Reset released; req_i=5'b00010 (WEST), packet header 0x0101, size 2, payload 0xA, 0xB; credit_i=1 -> grant_o=5'b00010 one cycle after the request. tx_o=1 for 4 consecutive cycles with data 0x0101, 2, 0xA, 0xB. pop_o[1]=1 on each of those cycles. busy_o=0 on the next cycle.
2. All 5 inputs requesting continuously with size-0 packets -> grant order EAST, WEST, NORTH, SOUTH, LOCAL, EAST. Each grant gives 2 transfers followed by 1 idle cycle.
3. Size 3 packet; credit_i=0 for 3 cycles after the first payload flit -> tx_o=0 and pop_o=0 during the stall, remaining holds at 2. The remaining 2 flits are sent in order after credit returns.
4. Owner WEST drops req_i for 2 cycles mid-payload while NORTH is requesting -> grant_o stays 5'b00010 and NORTH gets no pop. WEST resumes and completes the packet; NORTH is granted next.
5. reset pulsed mid-payload while owner is SOUTH -> grant_o, tx_o, pop_o and busy_o go to 0 without waiting for a clock edge. After release, with EAST and SOUTH both requesting, EAST is granted.
6. ARB_WATCHDOG_EN defined, WATCHDOG_LIMIT=8, credit_i=0 for 8 cycles in HEADER -> timeout_o=1 and remains 1 after traffic completes. Same stimulus without the macro -> timeout_o stays 0.
